// File: rtl/ps2_key_event_rx_pkg.sv
// Shared constants and types for the PS/2 key event receiver.
package ps2_key_event_rx_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         EV_W           = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Data byte plus parity bit must carry an odd number of ones.
  function automatic logic odd_ones(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_key_event_rx_fifo.sv
// Synchronous show-ahead event FIFO with count/full/empty and overflow strobe.
module ps2_event_fifo
  import ps2_key_event_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = EV_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_set_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (count == '0);
  assign full_o    = (count == CNT_W'(DEPTH));
  assign count_o   = count;
  assign do_pop    = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push   = push_i && (!full_o || do_pop);
  assign ovf_set_o = push_i && full_o && !do_pop;
  assign rdata_o   = empty_o ? '0 : mem[rd_ptr];

  // Storage array; no reset needed since reads are gated by empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: pin sync/filter, frame check with watchdog,
// E0/F0 prefix folding and an event FIFO.
//
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (falling clk with data low)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the odd-parity bit
//   ST_STOP   | checking stop bit and parity, then release byte or flag error
module ps2_key_event_rx
  import ps2_key_event_rx_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int DEPTH       = 8,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ps2_clk_i,
  input  logic             ps2_data_i,
  input  logic             rx_en_i,
  input  logic             pop_i,
  input  logic             clr_err_i,
  output logic             ev_valid_o,
  output logic [7:0]       ev_code_o,
  output logic             ev_ext_o,
  output logic             ev_brk_o,
  output logic [CNT_W-1:0] fifo_count_o,
  output logic             fifo_full_o,
  output logic             frame_err_o,
  output logic             ovf_o
);

  localparam int             FW          = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int             WW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0]  FILT_RELOAD = FW'(FILT_LEN - 1);
  localparam logic [WW-1:0]  WD_RELOAD   = WW'(TIMEOUT_CYC - 1);

  logic [1:0]   clk_sync;
  logic [1:0]   data_sync;
  logic         clk_s;
  logic         data_s;
  logic         filt_clk;
  logic [FW-1:0] filt_cnt;
  logic         fall_s;

  frame_state_t state;
  frame_state_t state_nx;
  logic [7:0]   shreg;
  logic [2:0]   bit_cnt;
  logic         par_bit;
  logic [WW-1:0] wd_cnt;
  logic         wd_expired;
  logic         shift_en;
  logic         par_ld;
  logic         byte_done;
  logic         frame_err;

  logic         byte_vld;
  logic [7:0]   rx_byte;
  logic         ext_flag;
  logic         brk_flag;
  logic         push;
  ps2_event_t   push_ev;
  ps2_event_t   head_ev;
  logic         empty;
  logic         ovf_set;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Two-flop synchronisers; reset to the idle-high bus level.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  // Clock deglitch: down-counter runs while the synced level disagrees with the filtered one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      filt_clk <= 1'b1;
      filt_cnt <= FILT_RELOAD;
    end else if (clk_s == filt_clk) begin
      filt_cnt <= FILT_RELOAD;
    end else if (filt_cnt == '0) begin
      filt_clk <= clk_s;
      filt_cnt <= FILT_RELOAD;
    end else begin
      filt_cnt <= filt_cnt - FW'(1);
    end
  end

  assign fall_s = filt_clk && !clk_s && (filt_cnt == '0);

  // Frame state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nx;
  end

  assign wd_expired = (state != ST_IDLE) && (wd_cnt == '0) && !fall_s;

  // Frame next-state and control strobes; enable and watchdog override bit handling.
  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    par_ld    = 1'b0;
    byte_done = 1'b0;
    frame_err = 1'b0;
    if (!rx_en_i) begin
      state_nx = ST_IDLE;
    end else if (wd_expired) begin
      state_nx  = ST_IDLE;
      frame_err = 1'b1;
    end else if (fall_s) begin
      case (state)
        ST_IDLE:   if (!data_s) state_nx = ST_DATA;
        ST_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        end
        ST_PARITY: begin
          par_ld   = 1'b1;
          state_nx = ST_STOP;
        end
        ST_STOP: begin
          state_nx = ST_IDLE;
          if (data_s && odd_ones({par_bit, shreg})) byte_done = 1'b1;
          else                                      frame_err = 1'b1;
        end
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // Shift register, bit counter, parity capture and watchdog down-counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      wd_cnt  <= WD_RELOAD;
    end else begin
      if (state == ST_IDLE) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {data_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_ld) par_bit <= data_s;
      if (state == ST_IDLE || fall_s) wd_cnt <= WD_RELOAD;
      else if (wd_cnt != '0)          wd_cnt <= wd_cnt - WW'(1);
    end
  end

  // Registered byte hand-off, error pulse, and prefix flag tracking.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_vld    <= 1'b0;
      rx_byte     <= '0;
      frame_err_o <= 1'b0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
    end else begin
      byte_vld    <= byte_done;
      frame_err_o <= frame_err;
      if (byte_done) rx_byte <= shreg;
      if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_vld) begin
        if (rx_byte == PS2_PREFIX_EXT)      ext_flag <= 1'b1;
        else if (rx_byte == PS2_PREFIX_BRK) brk_flag <= 1'b1;
        else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  assign push    = byte_vld && (rx_byte != PS2_PREFIX_EXT) && (rx_byte != PS2_PREFIX_BRK);
  assign push_ev = {ext_flag, brk_flag, rx_byte};

  ps2_event_fifo #(.DEPTH(DEPTH), .WIDTH(EV_W)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .wdata_i   (push_ev),
    .pop_i     (pop_i),
    .rdata_o   (head_ev),
    .count_o   (fifo_count_o),
    .full_o    (fifo_full_o),
    .empty_o   (empty),
    .ovf_set_o (ovf_set)
  );

  assign ev_valid_o = !empty;
  assign ev_code_o  = head_ev.code;
  assign ev_ext_o   = head_ev.ext;
  assign ev_brk_o   = head_ev.brk;

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)         ovf_o <= 1'b0;
    else if (ovf_set)   ovf_o <= 1'b1;
    else if (clr_err_i) ovf_o <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
`timescale 1ns/1ps
module tb_ps2_key_event_rx;

  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 200;
  localparam int DEPTH       = 8;
  localparam int CNT_W       = $clog2(DEPTH) + 1;
  localparam int H           = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ps2_clk, ps2_data, rx_en, clr_err;
  logic             mon_pop, man_pop, pop;
  logic             ev_valid, ev_ext, ev_brk, fifo_full, frame_err, ovf;
  logic [7:0]       ev_code;
  logic [CNT_W-1:0] fifo_count;

  assign pop = mon_pop | man_pop;

  ps2_key_event_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .rx_en_i(rx_en), .pop_i(pop), .clr_err_i(clr_err),
    .ev_valid_o(ev_valid), .ev_code_o(ev_code), .ev_ext_o(ev_ext), .ev_brk_o(ev_brk),
    .fifo_count_o(fifo_count), .fifo_full_o(fifo_full), .frame_err_o(frame_err), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] code; bit ext; bit brk; } ev_t;
  ev_t exp_q[$];
  int  vectors = 0, miscompares = 0;
  int  exp_err = 0, obs_err = 0;
  bit  m_ext = 0, m_brk = 0, m_ovf = 0;
  bit  auto_pop = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model at byte level: prefix bytes set flags, errors clear them, others make events.
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!auto_pop && exp_q.size() == DEPTH) m_ovf = 1;
      else exp_q.push_back('{b, m_ext, m_brk});
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Monitor: whenever an event is presented and draining is enabled, compare and pop it.
  always @(negedge clk) begin
    if (rst_n && auto_pop && ev_valid) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_event: got code %0h ext %0b brk %0b, expected none", ev_code, ev_ext, ev_brk);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_code", ev_code, e.code);
        check("ev_ext", ev_ext, e.ext);
        check("ev_brk", ev_brk, e.brk);
      end
      mon_pop = 1;
    end else mon_pop = 0;
  end

  always @(negedge clk) if (frame_err) obs_err++;

  task automatic ps2_bit(input logic b, input int glitch, input bit do_pop);
    ps2_data = b;
    if (glitch > 0) begin
      repeat (H/2) @(negedge clk);
      ps2_clk = 0; repeat (glitch) @(negedge clk); ps2_clk = 1;
      repeat (H - H/2 - glitch) @(negedge clk);
    end else repeat (H) @(negedge clk);
    ps2_clk = 0;
    if (do_pop) begin
      repeat (6) @(negedge clk);
      man_pop = 1; @(negedge clk); man_pop = 0;
      repeat (H - 7) @(negedge clk);
    end else if (glitch > 0) begin
      repeat (H/2) @(negedge clk);
      ps2_clk = 1; repeat (glitch) @(negedge clk); ps2_clk = 0;
      repeat (H - H/2 - glitch) @(negedge clk);
    end else repeat (H) @(negedge clk);
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch, input bit pop_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], glitch, pop_stop && (i == 10));
    ps2_data = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch);
    model_byte(b, !(bad_par || bad_stop));
    send_frame(b, bad_par, bad_stop, glitch, 0, 11);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    auto_pop = 1;
    while ((exp_q.size() != 0 || ev_valid) && t < 500) begin @(negedge clk); t++; end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] code;
    bit e, k;
    int g;
    rst_n = 0; ps2_clk = 1; ps2_data = 1; rx_en = 1; clr_err = 0; man_pop = 0; mon_pop = 0;
    repeat (5) @(negedge clk);
    check("rst_valid", ev_valid, 0);
    check("rst_code", ev_code, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", fifo_full, 0);
    check("rst_err", frame_err, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1;
    repeat (5) @(negedge clk);

    // Single plain key.
    send(8'h1C, 0, 0, 0);
    check("t1_count", fifo_count, 1);
    check("t1_valid", ev_valid, 1);
    check("t1_code", ev_code, 8'h1C);
    check("t1_extbrk", {ev_ext, ev_brk}, 0);
    check("t1_err", obs_err, 0);
    drain("t1_drain");

    // Prefix folding.
    send(8'hF0, 0, 0, 0); send(8'h1C, 0, 0, 0);
    send(8'hE0, 0, 0, 0); send(8'hF0, 0, 0, 0); send(8'h75, 0, 0, 0);
    drain("t2_drain");

    // Parity error, then an error after a lone F0 must clear the flag.
    send(8'h1C, 1, 0, 0);
    check("t3_count", fifo_count, 0);
    check("t3_err", obs_err, exp_err);
    send(8'hF0, 0, 0, 0); send(8'h55, 0, 1, 0);
    send(8'hE0, 0, 0, 0); send(8'h74, 0, 0, 0);
    drain("t3_drain");
    check("t3_err2", obs_err, exp_err);

    // Watchdog: truncated frame after an E0 prefix.
    send(8'hE0, 0, 0, 0);
    send_frame(8'h3A, 0, 0, 0, 0, 5);
    repeat (100) @(negedge clk);
    check("t4_no_early_err", obs_err, exp_err);
    model_byte(8'h00, 0);
    repeat (150) @(negedge clk);
    check("t4_timeout_err", obs_err, exp_err);
    send(8'h29, 0, 0, 0);
    drain("t4_drain");

    // Glitches and receive-enable drop mid-frame (prefix survives the drop).
    send(8'h5A, 0, 0, FILT_LEN - 1);
    send(8'hE0, 0, 0, 1);
    send_frame(8'h66, 0, 0, 0, 0, 3);
    rx_en = 0; repeat (10) @(negedge clk); rx_en = 1; repeat (10) @(negedge clk);
    send(8'h74, 0, 0, 0);
    drain("t6_drain");
    check("t6_err", obs_err, exp_err);

    // Randomised key traffic with occasional corrupted frames and glitches.
    for (int n = 0; n < 20; n++) begin
      do code = 8'($urandom_range(0, 255)); while (code == 8'hE0 || code == 8'hF0);
      e = $urandom_range(0, 1) == 1;
      k = $urandom_range(0, 1) == 1;
      g = $urandom_range(0, FILT_LEN - 1);
      if (e) send(8'hE0, 0, 0, g);
      if (k) send(8'hF0, 0, 0, g);
      if ($urandom_range(0, 5) == 0) send(code, 1'($urandom_range(0, 1)), 1'b1, g);
      send(code, 0, 0, g);
    end
    drain("rand_drain");
    check("rand_err", obs_err, exp_err);

    // Overflow, push+pop when full, and clear.
    auto_pop = 0;
    for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i), 0, 0, 0);
    check("t5_count", fifo_count, DEPTH);
    check("t5_full", fifo_full, 1);
    check("t5_ovf", ovf, m_ovf);
    check("t5_head", ev_code, exp_q[0].code);
    clr_err = 1; @(negedge clk); clr_err = 0;
    check("t5_clr", ovf, 0);
    void'(exp_q.pop_front());
    model_byte(8'h42, 1);
    send_frame(8'h42, 0, 0, 0, 1, 11);
    check("t5_pp_count", fifo_count, DEPTH);
    check("t5_pp_ovf", ovf, 0);
    check("t5_pp_head", ev_code, exp_q[0].code);
    drain("t5_drain");

    // Reset in the middle of a frame with events stored.
    auto_pop = 0;
    send(8'h21, 0, 0, 0); send(8'h22, 0, 0, 0);
    send_frame(8'h23, 0, 0, 0, 0, 4);
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("mrst_valid", ev_valid, 0);
    check("mrst_count", fifo_count, 0);
    check("mrst_code", {ev_code, ev_ext, ev_brk}, 0);
    check("mrst_flags", {fifo_full, frame_err, ovf}, 0);
    exp_q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
    ps2_clk = 1; ps2_data = 1;
    repeat (5) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    send(8'h33, 0, 0, 0);
    drain("post_rst_drain");
    check("final_err", obs_err, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
